// File: rtl/riscv_bus_pkg.sv
// rtl/riscv_bus_pkg.sv - shared arbiter state encoding, request bundle and error constants
package riscv_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_req_t;

  localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEADBEEF;

  function automatic arb_state_e gnt_state(input logic idx);
    return idx ? ST_GNT1 : ST_GNT0;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin grant decision
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_idx
);

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_idx   = 1'b0;
    if (req0 && req1) begin
      // on a tie the master that did not win last time goes first
      gnt_idx = ~last_grant;
    end else if (req1) begin
      gnt_idx = 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master shared memory bus arbiter with stall timeout
module mem_bus_arbiter
  import riscv_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = DEFAULT_ERR_RDATA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        bus_err,
  output logic        err_master
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             err_master_q, err_master_d;

  bus_req_t m0_req, m1_req, sel_req;
  logic     granted, sel_idx, sel_valid, timeout;
  logic     gnt_valid, gnt_idx;
  logic     resp_ready;
  logic [31:0] resp_rdata;

  assign m0_req    = {m0_valid, m0_addr, m0_wdata, m0_wstrb};
  assign m1_req    = {m1_valid, m1_addr, m1_wdata, m1_wstrb};
  assign granted   = (state_q != ST_IDLE);
  assign sel_idx   = (state_q == ST_GNT1);
  assign sel_req   = sel_idx ? m1_req : m0_req;
  assign sel_valid = granted & sel_req.valid;
  // a memory response in the last allowed cycle beats the timeout
  assign timeout   = sel_valid & ~s_ready & (stall_cnt_q == CNT_LAST);

  rr_arb2 u_rr_arb2 (
    .req0       (m0_valid),
    .req1       (m1_valid),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      stall_cnt_q  <= '0;
      err_master_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      stall_cnt_q  <= stall_cnt_d;
      err_master_q <= err_master_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    stall_cnt_d  = stall_cnt_q;
    err_master_d = err_master_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          state_d      = gnt_state(gnt_idx);
          last_grant_d = gnt_idx;
          stall_cnt_d  = '0;
        end
      end
      ST_GNT0, ST_GNT1: begin
        if (!sel_req.valid || s_ready) begin
          state_d = ST_IDLE;
        end else if (timeout) begin
          state_d      = ST_IDLE;
          err_master_d = sel_idx;
        end else if (stall_cnt_q != CNT_LAST) begin
          stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_valid    = 1'b0;
    s_addr     = '0;
    s_wdata    = '0;
    s_wstrb    = '0;
    m0_ready   = 1'b0;
    m0_rdata   = '0;
    m1_ready   = 1'b0;
    m1_rdata   = '0;
    bus_err    = 1'b0;
    resp_ready = 1'b0;
    resp_rdata = '0;
    if (granted) begin
      s_valid    = sel_req.valid & ~timeout;
      s_addr     = sel_req.addr;
      s_wdata    = sel_req.wdata;
      s_wstrb    = sel_req.wstrb;
      // a transaction caught by reset completes silently
      resp_ready = rst & ((sel_valid & s_ready) | timeout);
      resp_rdata = timeout ? ERR_RDATA : s_rdata;
      bus_err    = rst & timeout;
      if (sel_idx) begin
        m1_ready = resp_ready;
        m1_rdata = resp_rdata;
      end else begin
        m0_ready = resp_ready;
        m0_rdata = resp_rdata;
      end
    end
  end

  assign err_master = err_master_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  localparam int          TO   = 8;
  localparam logic [31:0] A0   = 32'h0000_0010;
  localparam logic [31:0] A1   = 32'h0000_1000;
  localparam logic [31:0] WD1  = 32'h6A09_E667;
  localparam logic [31:0] ERRV = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_valid, m0_ready, m1_valid, m1_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        s_valid, s_ready, bus_err, err_master;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;

  int checks   = 0;
  int failures = 0;
  logic exp_em = 1'b0;

  int   owner;
  int   age;
  int   last;
  logic mem;

  typedef struct {
    logic         rstn;
    logic         m0v;
    logic         m1v;
    logic         sr;
    logic [31:0]  srd;
    logic [136:0] exp;
  } vec_t;
  vec_t vecs[$];

  mem_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .bus_err(bus_err), .err_master(err_master)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [136:0] act, input logic [136:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [136:0] pk(input logic sv, input logic [31:0] sa, input logic [31:0] swd,
                                      input logic [3:0] sws, input logic r0, input logic [31:0] rd0,
                                      input logic r1, input logic [31:0] rd1, input logic be,
                                      input logic em_i);
    return {sv, sa, swd, sws, r0, rd0, r1, rd1, be, em_i};
  endfunction

  function automatic logic [136:0] dut_obs();
    return pk(s_valid, s_addr, s_wdata, s_wstrb, m0_ready, m0_rdata, m1_ready, m1_rdata,
              bus_err, err_master);
  endfunction

  function automatic vec_t row(input logic rn, input logic m0v, input logic m1v, input logic sr,
                               input logic [31:0] srd, input logic sv, input int sel,
                               input logic r0, input logic [31:0] rd0,
                               input logic r1, input logic [31:0] rd1);
    vec_t v;
    logic [31:0] a, wd;
    logic [3:0]  ws;
    a  = (sel == 1) ? A0 : (sel == 2) ? A1 : 32'h0;
    wd = (sel == 2) ? WD1 : 32'h0;
    ws = (sel == 2) ? 4'hF : 4'h0;
    v.rstn = rn; v.m0v = m0v; v.m1v = m1v; v.sr = sr; v.srd = srd;
    v.exp  = pk(sv, a, wd, ws, r0, rd0, r1, rd1, 1'b0, 1'b0);
    return v;
  endfunction

  // reference: whoever owns the bus sees memory directly; a request that has
  // waited TO cycles without memory response is closed with an error
  function automatic logic [136:0] model_expect();
    logic        sv = 1'b0, r0 = 1'b0, r1 = 1'b0, be = 1'b0, v, timed, r;
    logic [31:0] sa = '0, swd = '0, rd0 = '0, rd1 = '0, rd;
    logic [3:0]  sws = '0;
    if (owner >= 0) begin
      v     = (owner == 1) ? m1_valid : m0_valid;
      sa    = (owner == 1) ? m1_addr  : m0_addr;
      swd   = (owner == 1) ? m1_wdata : m0_wdata;
      sws   = (owner == 1) ? m1_wstrb : m0_wstrb;
      timed = v && !s_ready && (age == TO - 1);
      sv    = v && !timed;
      r     = v && (s_ready || timed);
      rd    = timed ? ERRV : s_rdata;
      be    = timed;
      if (owner == 1) begin r1 = r; rd1 = rd; end
      else            begin r0 = r; rd0 = rd; end
    end
    return pk(sv, sa, swd, sws, r0, rd0, r1, rd1, be, mem);
  endfunction

  task automatic model_update();
    logic v;
    if (!rst) begin
      owner = -1; last = 1; age = 0; mem = 1'b0;
    end else if (owner < 0) begin
      if (m0_valid && m1_valid) owner = 1 - last;
      else if (m0_valid)        owner = 0;
      else if (m1_valid)        owner = 1;
      if (owner >= 0) begin last = owner; age = 0; end
    end else begin
      v = (owner == 1) ? m1_valid : m0_valid;
      if (!v || s_ready) owner = -1;
      else if (age == TO - 1) begin mem = (owner == 1); owner = -1; end
      else age++;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic stall_seq(input logic m, input logic hit);
    logic [31:0] rd;
    logic        is_last;
    m0_valid = !m; m1_valid = m; s_ready = 1'b0; s_rdata = '0;
    @(negedge clk);
    check("to_idle_s_valid", 137'(s_valid), 137'(0));
    next_cycle();
    for (int k = 0; k < TO; k++) begin
      is_last = (k == TO - 1);
      rd      = $urandom;
      s_rdata = rd;
      s_ready = is_last && hit;
      @(negedge clk);
      check("to_ready", 137'(m ? m1_ready : m0_ready), 137'(is_last));
      check("to_other_ready", 137'(m ? m0_ready : m1_ready), 137'(0));
      check("to_rdata", 137'(m ? m1_rdata : m0_rdata), 137'((is_last && !hit) ? ERRV : rd));
      check("to_bus_err", 137'(bus_err), 137'(is_last && !hit));
      check("to_s_valid", 137'(s_valid), 137'(!(is_last && !hit)));
      check("to_err_master", 137'(err_master), 137'(exp_em));
      next_cycle();
    end
    if (!hit) exp_em = m;
    m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
    @(negedge clk);
    check("to_after_s_valid", 137'(s_valid), 137'(0));
    check("to_after_bus_err", 137'(bus_err), 137'(0));
    check("to_after_err_master", 137'(err_master), 137'(exp_em));
    next_cycle();
  endtask

  initial begin
    logic saw0, saw1;
    logic act[2];

    rst = 1'b0; s_ready = 1'b0; s_rdata = '0;
    m0_valid = 1'b0; m0_addr = A0; m0_wdata = '0;  m0_wstrb = 4'h0;
    m1_valid = 1'b0; m1_addr = A1; m1_wdata = WD1; m1_wstrb = 4'hF;
    repeat (3) next_cycle();
    @(negedge clk);
    check("reset_outputs", dut_obs(), 137'(0));
    next_cycle();
    rst = 1'b1;

    // rstn m0v m1v sr srd | s_valid sel m0_ready m0_rdata m1_ready m1_rdata
    vecs.push_back(row(1, 1, 0, 0, 32'h0,         0, 0, 0, 32'h0,         0, 32'h0));
    vecs.push_back(row(1, 1, 0, 0, 32'h0,         1, 1, 0, 32'h0,         0, 32'h0));
    vecs.push_back(row(1, 1, 0, 0, 32'h0,         1, 1, 0, 32'h0,         0, 32'h0));
    vecs.push_back(row(1, 1, 0, 1, 32'h1122_3344, 1, 1, 1, 32'h1122_3344, 0, 32'h0));
    vecs.push_back(row(1, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0,         0, 32'h0));
    vecs.push_back(row(0, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0,         0, 32'h0));
    vecs.push_back(row(1, 1, 1, 0, 32'h0,         0, 0, 0, 32'h0,         0, 32'h0));
    vecs.push_back(row(1, 1, 1, 1, 32'hA5A5_0001, 1, 1, 1, 32'hA5A5_0001, 0, 32'h0));
    vecs.push_back(row(1, 0, 1, 0, 32'h0,         0, 0, 0, 32'h0,         0, 32'h0));
    vecs.push_back(row(1, 0, 1, 1, 32'hA5A5_0002, 1, 2, 0, 32'h0,         1, 32'hA5A5_0002));
    vecs.push_back(row(1, 1, 1, 0, 32'h0,         0, 0, 0, 32'h0,         0, 32'h0));
    vecs.push_back(row(1, 1, 1, 1, 32'hA5A5_0003, 1, 1, 1, 32'hA5A5_0003, 0, 32'h0));
    vecs.push_back(row(1, 1, 1, 0, 32'h0,         0, 0, 0, 32'h0,         0, 32'h0));
    vecs.push_back(row(1, 1, 1, 1, 32'hA5A5_0004, 1, 2, 0, 32'h0,         1, 32'hA5A5_0004));
    vecs.push_back(row(1, 0, 1, 0, 32'h0,         0, 0, 0, 32'h0,         0, 32'h0));
    vecs.push_back(row(1, 1, 1, 0, 32'h0,         1, 2, 0, 32'h0,         0, 32'h0));
    vecs.push_back(row(1, 1, 1, 0, 32'h0,         1, 2, 0, 32'h0,         0, 32'h0));
    vecs.push_back(row(1, 1, 1, 1, 32'hA5A5_0005, 1, 2, 0, 32'h0,         1, 32'hA5A5_0005));
    vecs.push_back(row(1, 1, 0, 0, 32'h0,         0, 0, 0, 32'h0,         0, 32'h0));
    vecs.push_back(row(1, 1, 0, 1, 32'hA5A5_0006, 1, 1, 1, 32'hA5A5_0006, 0, 32'h0));
    vecs.push_back(row(1, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0,         0, 32'h0));

    foreach (vecs[i]) begin
      rst = vecs[i].rstn; m0_valid = vecs[i].m0v; m1_valid = vecs[i].m1v;
      s_ready = vecs[i].sr; s_rdata = vecs[i].srd;
      @(negedge clk);
      check($sformatf("vec%0d", i), dut_obs(), vecs[i].exp);
      next_cycle();
    end
    rst = 1'b1; m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;

    stall_seq(1'b1, 1'b0);
    stall_seq(1'b0, 1'b1);
    stall_seq(1'b0, 1'b0);

    // granted master abandons its request
    m0_valid = 1'b1;
    @(negedge clk); next_cycle();
    @(negedge clk);
    check("drop_s_valid_before", 137'(s_valid), 137'(1));
    next_cycle();
    m0_valid = 1'b0;
    @(negedge clk);
    check("drop_s_valid", 137'(s_valid), 137'(0));
    check("drop_m0_ready", 137'(m0_ready), 137'(0));
    next_cycle();
    m1_valid = 1'b1;
    @(negedge clk);
    check("drop_idle_addr", 137'(s_addr), 137'(0));
    next_cycle();
    s_ready = 1'b1; s_rdata = 32'h5555_AAAA;
    @(negedge clk);
    check("drop_m1_addr", 137'(s_addr), 137'(A1));
    check("drop_m1_ready", 137'(m1_ready), 137'(1));
    next_cycle();
    m1_valid = 1'b0; s_ready = 1'b0;

    // reset while accelerator is stalled
    @(negedge clk); next_cycle();
    m1_valid = 1'b1;
    @(negedge clk); next_cycle();
    @(negedge clk);
    check("rst_gnt1_addr", 137'(s_addr), 137'(A1));
    next_cycle();
    rst = 1'b0; s_ready = 1'b1; s_rdata = 32'h1234_5678;
    @(negedge clk);
    check("rst_no_m1_ready", 137'(m1_ready), 137'(0));
    check("rst_no_bus_err", 137'(bus_err), 137'(0));
    next_cycle();
    rst = 1'b1; s_ready = 1'b0; m0_valid = 1'b1; m1_valid = 1'b1; exp_em = 1'b0;
    @(negedge clk);
    check("rst_idle_s_valid", 137'(s_valid), 137'(0));
    check("rst_err_master", 137'(err_master), 137'(exp_em));
    next_cycle();
    s_ready = 1'b1; s_rdata = 32'h0F0F_0F0F;
    @(negedge clk);
    check("rst_tie_cpu_addr", 137'(s_addr), 137'(A0));
    check("rst_tie_cpu_ready", 137'(m0_ready), 137'(1));
    next_cycle();
    m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;

    // randomized traffic against the reference model
    rst = 1'b0;
    repeat (2) next_cycle();
    rst = 1'b1;
    owner = -1; last = 1; age = 0; mem = 1'b0;
    act[0] = 1'b0; act[1] = 1'b0; saw0 = 1'b0; saw1 = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (saw0) act[0] = 1'b0;
      if (saw1) act[1] = 1'b0;
      if (!act[0]) begin
        act[0] = ($urandom_range(0, 2) == 0);
        m0_addr = $urandom; m0_wdata = $urandom; m0_wstrb = 4'($urandom);
      end
      if (!act[1]) begin
        act[1] = ($urandom_range(0, 2) == 0);
        m1_addr = $urandom; m1_wdata = $urandom; m1_wstrb = 4'($urandom);
      end
      m0_valid = act[0]; m1_valid = act[1];
      s_ready  = ($urandom_range(0, 9) < 2);
      s_rdata  = $urandom;
      @(negedge clk);
      check($sformatf("rand%0d", c), dut_obs(), model_expect());
      saw0 = m0_ready; saw1 = m1_ready;
      @(posedge clk);
      model_update();
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
